// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, ALU operation codes and FSM states.
package riscv_ctrl_pkg;

  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm  = 7'b0010011;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSll = 4'b0011;
  localparam logic [3:0] AluSlt = 4'b0100;
  localparam logic [3:0] AluXor = 4'b0101;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSrl = 4'b0111;
  localparam logic [3:0] AluSra = 4'b1000;

  typedef enum logic [2:0] {
    StIf,
    StId,
    StEx,
    StMem,
    StWb,
    StHalt
  } ctrl_state_e;

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational decode of {opcode, funct3, funct7[5]} into an ALU operation code and an illegal flag.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl,
  output logic       illegal_op
);

  always_comb begin
    alu_ctrl   = AluAdd;
    illegal_op = 1'b0;
    case (opcode)
      OpcodeOp, OpcodeOpImm: begin
        unique case (funct3)
          // Bit 30 of an ADDI immediate must not turn it into a subtract.
          3'b000: alu_ctrl = (funct7_5 && (opcode == OpcodeOp)) ? AluSub : AluAdd;
          3'b001: alu_ctrl = AluSll;
          // The ALU has no unsigned compare; SLTU/SLTIU share the SLT code.
          3'b010, 3'b011: alu_ctrl = AluSlt;
          3'b100: alu_ctrl = AluXor;
          3'b101: alu_ctrl = funct7_5 ? AluSra : AluSrl;
          3'b110: alu_ctrl = AluOr;
          3'b111: alu_ctrl = AluAnd;
          default: alu_ctrl = AluAdd;
        endcase
      end
      OpcodeLoad, OpcodeStore: alu_ctrl = AluAdd;
      OpcodeBranch: begin
        alu_ctrl = AluSub;
        if (funct3[2:1] != 2'b00) begin
          illegal_op = 1'b1;
        end
      end
      default: illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB control FSM with instruction register and registered control outputs.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions; otherwise they execute as a NOP.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_rdata,
  input  logic        zero,
  input  logic        dmem_ready,
  output logic [31:0] ir,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal
);

  ctrl_state_e state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] dec_alu;
  logic       dec_illegal;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];

  riscv_alu_decoder u_alu_decoder (
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (ir[30]),
    .alu_ctrl   (dec_alu),
    .illegal_op (dec_illegal)
  );

  logic is_alu_r, is_alu_i, is_load, is_store, is_branch, is_bne;

  assign is_alu_r  = (opcode == OpcodeOp);
  assign is_alu_i  = (opcode == OpcodeOpImm);
  assign is_load   = (opcode == OpcodeLoad);
  assign is_store  = (opcode == OpcodeStore);
  assign is_branch = (opcode == OpcodeBranch) && !dec_illegal;
  assign is_bne    = funct3[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIf: state_d = StId;
      StId: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        state_d = dec_illegal ? StHalt : StEx;
`else
        state_d = StEx;
`endif
      end
      StEx:    state_d = (is_load || is_store) ? StMem : StWb;
      StMem:   state_d = dmem_ready ? StWb : StMem;
      StWb:    state_d = StIf;
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  // Outputs are registered against the state being entered, so they are Moore in (state, ir).
  logic in_exec_d, in_mem_d, in_wb_d;

  assign in_exec_d = (state_d == StEx || state_d == StMem || state_d == StWb) && !dec_illegal;
  assign in_mem_d  = (state_d == StMem);
  assign in_wb_d   = (state_d == StWb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIf;
      ir       <= NOP_INSTR;
      ALUSrc   <= 1'b0;
      ALUCtrl  <= AluAnd;
      RegWrite <= 1'b0;
      MemtoReg <= 1'b0;
      loadPC   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StIf) begin
        ir <= imem_rdata;
      end
      ALUCtrl  <= in_exec_d ? dec_alu : AluAnd;
      ALUSrc   <= in_exec_d && (is_alu_i || is_load || is_store);
      MemWrite <= in_mem_d && is_store;
      MemRead  <= (in_mem_d || in_wb_d) && is_load;
      MemtoReg <= (in_mem_d || in_wb_d) && is_load;
      RegWrite <= in_wb_d && (is_alu_r || is_alu_i || is_load);
      loadPC   <= in_wb_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (state_q == StId && dec_illegal) begin
        illegal <= 1'b1;
      end
`endif
    end
  end

`ifndef CTRL_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  // Branch resolution uses the live zero flag; ALU inputs are held stable through WB.
  assign PCSrc = loadPC && is_branch && (zero ^ is_bne);

endmodule
